signed_saturator: RTL and testbench
===================================

# signed_saturator

Streaming stage directly downstream of `signed_rounder`. It takes the rounded signed integer and narrows it to a smaller signed width, either by saturating or by wrapping. Each output beat carries a per-beat overflow flag, and the block also keeps a sticky overflow flag and, optionally, an overflow event counter. The valid/ready handshake runs at full throughput behind a 2-entry skid buffer, so a rounder-plus-saturator chain can be backpressured without stalls.

## Interface
- `in_width`, 8: input width; matches the rounder's `int_width`.
- `out_width`, 6: output width; must satisfy 2 ≤ `out_width` ≤ `in_width` (elaboration error otherwise).
- `method`, "SATURATE": selects "SATURATE" or "WRAP"; any other string is an elaboration error.
- `cnt_width`, 16: width of the overflow counter.
- `clk` in 1: clock; all logic on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `s_valid` in 1: input beat valid.
- `s_ready` out 1: input beat accepted when `s_valid` and `s_ready` are both high.
- `s_data` in `in_width`: signed input.
- `m_valid` out 1: output beat valid.
- `m_ready` in 1: downstream ready.
- `m_data` out `out_width`: signed narrowed result.
- `m_ovf` out 1: the current output beat overflowed.
- `ovf_sticky` out 1: at least one overflow since reset or the last clear.
- `clr_sticky` in 1: single-cycle clear of `ovf_sticky` and `ovf_count`.
- `ovf_count` out `cnt_width`: saturating count of overflowed beats. Present only with `SIGNED_SATURATOR_STATS_EN`.

## Operation
- Representable range: MIN = -2^(out_width-1), MAX = 2^(out_width-1)-1.
- Overflow: `ovf` = `s_data` > MAX or `s_data` < MIN, computed at full `in_width`.
- SATURATE mode: result is MAX if above range, MIN if below range, otherwise `s_data` sign-truncated.
- WRAP mode: result is `s_data[out_width-1:0]`; `ovf` is still flagged.
- When `out_width` == `in_width`: pass-through, and `ovf` is constantly 0.
- `ovf` travels with its data word through the buffer as `m_ovf`.
- Sticky flag: set on an accepted beat with `ovf`=1. `clr_sticky` clears it. If set and clear occur in the same cycle, set wins and the flag reads 1 next cycle.
- Counter: increments on an accepted overflowed beat and holds at all-ones. `clr_sticky` loads 0. If clear and increment occur in the same cycle, the counter becomes 1.
- Skid buffer state machine, where "accept" means input beat accepted and "drain" means `m_valid` and `m_ready` both high:
  - EMPTY: `m_valid`=0, `s_ready`=1. Accept → ONE.
  - ONE: output register full, `s_ready`=1.
    - Accept and drain → ONE (output register reloads).
    - Accept with no drain → TWO (beat goes to the skid register).
    - Drain with no accept → EMPTY.
  - TWO: `s_ready`=0. Drain → ONE; the skid register moves into the output register.
- Ordering is strictly FIFO. No beat is dropped or duplicated.
- `m_data`/`m_ovf` hold steady while `m_valid`=1 and `m_ready`=0.

## Timing
- Latency: an accepted beat appears on `m_data` the next cycle when the buffer is EMPTY, or when in ONE with a drain in the same cycle.
- Throughput: 1 beat/cycle while `m_ready`=1.
- `s_ready` is a registered output, derived from state only. It does not combinationally depend on `m_ready`.
- While `rst`=1: `s_ready`=0. In the first cycle after `rst` falls: `s_ready`=1.
- Reset values: `m_valid`=0, `m_data`=0, `m_ovf`=0, `ovf_sticky`=0, `ovf_count`=0.
- State after reset is EMPTY.
- Reset mid-operation discards buffered beats; `m_valid`=0 the cycle after `rst` is sampled.

## Configuration
- `SIGNED_SATURATOR_STATS_EN` defined: the `ovf_count` port and counter logic are compiled in.
- Macro undefined: no port and no counter. `ovf_sticky` and `clr_sticky` remain.

## Structure
- Package `rounding` gains:
  - enum `overflow_method` {`saturate`, `wrap`};
  - a string-to-enum conversion function;
  - pure function `narrow_explicit(value, out_width, overflow_method)` returning the result and the `ovf` flag, for use as the bench reference model.
- One sub-module, `skid_buffer`, parameterised on payload width. Its payload is {`ovf`, result}.

## Test plan
Defaults: `in_width`=8, `out_width`=6, so MIN = -32 and MAX = 31.
- SATURATE: inputs 100, -100, 31, -32, 0 → `m_data` 31, -32, 31, -32, 0 with `m_ovf` 1, 1, 0, 0, 0. `ovf_sticky`=1 after the first beat.
- WRAP: inputs 40, -40 → `m_data` -24, 24 with `m_ovf`=1. Input 5 → 5 with `m_ovf`=0.
- Backpressure: stream 1, 2, 3, 4 with `m_ready`=0 for 3 cycles:
  - 1 and 2 are accepted, then `s_ready`=0;
  - after `m_ready` returns high, output is 1, 2, 3, 4 in order with no gaps.
- With the macro defined and `cnt_width`=2: five overflowed beats → `ovf_count`=3. `clr_sticky` coinciding with an overflowed beat → count 1, sticky 1.
- Reset mid-stream while in state TWO: `m_valid`=0 the next cycle. After release, the first new beat (7) emerges alone with `m_ovf`=0.
- Random 10k beats in each mode, with random `m_ready` at 70% duty: outputs match `narrow_explicit` in order.

Source files
------------

// File: rtl/signed_saturator_pkg.sv
// -----------------------------------------------------------------------------
// signed_saturator_pkg
// Shared types and helpers for the signed_saturator slice.
//   overflow_method      : saturate / wrap narrowing behaviour
//   skid_state_e         : occupancy states of the 2-entry skid buffer
//   method_valid()       : true for the two accepted method strings
//   method_from_string() : "SATURATE"/"WRAP" string parameter -> enum
//   narrow_explicit()    : plain-arithmetic narrowing, usable as a reference
// -----------------------------------------------------------------------------
package signed_saturator_pkg;

    typedef enum logic {
        saturate = 1'b0,
        wrap     = 1'b1
    } overflow_method;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_TWO   = 2'd2
    } skid_state_e;

    typedef struct packed {
        logic               ovf;
        logic signed [63:0] result;
    } narrow_result_t;

    // Method strings are carried as 64-bit packed literals; "WRAP" is
    // zero-padded on the left when stored in the 64-bit parameter.
    function automatic logic method_valid(input logic [63:0] name);
        return (name == "SATURATE") || (name == {32'd0, "WRAP"});
    endfunction

    function automatic overflow_method method_from_string(input logic [63:0] name);
        return (name == {32'd0, "WRAP"}) ? wrap : saturate;
    endfunction

    function automatic narrow_result_t narrow_explicit(input longint         value,
                                                       input int             out_width,
                                                       input overflow_method m);
        narrow_result_t r;
        longint max_v;
        longint min_v;
        longint span;
        longint wrapped;
        max_v   = (longint'(1) <<< (out_width - 1)) - 1;
        min_v   = -max_v - 1;
        span    = longint'(1) <<< out_width;
        r.ovf   = (value > max_v) || (value < min_v);
        if (m == saturate) begin
            if (value > max_v)      r.result = max_v;
            else if (value < min_v) r.result = min_v;
            else                    r.result = value;
        end else begin
            wrapped = (value - min_v) % span;
            if (wrapped < 0) wrapped = wrapped + span;
            r.result = wrapped + min_v;
        end
        return r;
    endfunction

endpackage

// File: rtl/signed_saturator_if.sv
// -----------------------------------------------------------------------------
// signed_saturator_if
// Streaming handshake bundle around the saturator.
//   s_valid/s_ready/s_data        : upstream beat (from the rounder)
//   m_valid/m_ready/m_data/m_ovf  : downstream beat plus per-beat overflow
// Modports:
//   master : the environment side (drives s_*, m_ready)
//   slave  : the saturator side   (drives s_ready, m_valid, m_data, m_ovf)
// -----------------------------------------------------------------------------
interface signed_saturator_if #(
    parameter int in_width  = 8,
    parameter int out_width = 6
);
    logic                        s_valid;
    logic                        s_ready;
    logic signed [in_width-1:0]  s_data;
    logic                        m_valid;
    logic                        m_ready;
    logic signed [out_width-1:0] m_data;
    logic                        m_ovf;

    modport master (
        output s_valid, s_data, m_ready,
        input  s_ready, m_valid, m_data, m_ovf
    );

    modport slave (
        input  s_valid, s_data, m_ready,
        output s_ready, m_valid, m_data, m_ovf
    );
endinterface

// File: rtl/signed_saturator_skid_buffer.sv
// -----------------------------------------------------------------------------
// skid_buffer
// Two-entry registered skid buffer, full throughput, strict FIFO order.
// s_ready_o is registered and depends on occupancy only.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   s_valid_i/s_ready_o   : input handshake
//   s_data_i              : input payload (width bits)
//   m_valid_i/m_ready_i   : output handshake (m_valid_o out, m_ready_i in)
//   m_data_o              : output payload
//
// state      | meaning
// -----------+-----------------------------------------------------
// SKID_EMPTY | nothing buffered, m_valid=0, s_ready=1
// SKID_ONE   | output register full, skid empty, s_ready=1
// SKID_TWO   | output and skid registers full, s_ready=0
// -----------------------------------------------------------------------------
module skid_buffer
    import signed_saturator_pkg::*;
#(
    parameter int width = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid_i,
    output logic             s_ready_o,
    input  logic [width-1:0] s_data_i,
    output logic             m_valid_o,
    input  logic             m_ready_i,
    output logic [width-1:0] m_data_o
);

    skid_state_e      state_q, state_d;
    logic [width-1:0] out_q, out_d;
    logic [width-1:0] skid_q, skid_d;
    logic             s_ready_q, s_ready_d;
    logic             accept;
    logic             drain;

    assign accept    = s_valid_i && s_ready_q;
    assign drain     = m_valid_o && m_ready_i;
    assign m_valid_o = (state_q != SKID_EMPTY);
    assign m_data_o  = out_q;
    assign s_ready_o = s_ready_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= SKID_EMPTY;
            out_q     <= '0;
            skid_q    <= '0;
            s_ready_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            out_q     <= out_d;
            skid_q    <= skid_d;
            s_ready_q <= s_ready_d;
        end
    end

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        skid_d  = skid_q;
        case (state_q)
            SKID_EMPTY: begin
                if (accept) begin
                    out_d   = s_data_i;
                    state_d = SKID_ONE;
                end
            end
            SKID_ONE: begin
                if (accept && drain) begin
                    out_d = s_data_i;
                end else if (accept) begin
                    skid_d  = s_data_i;
                    state_d = SKID_TWO;
                end else if (drain) begin
                    state_d = SKID_EMPTY;
                end
            end
            SKID_TWO: begin
                if (drain) begin
                    out_d   = skid_q;
                    state_d = SKID_ONE;
                end
            end
            default: state_d = SKID_EMPTY;
        endcase
        // Registered ready: looks at where we are going, never at m_ready now.
        s_ready_d = (state_d != SKID_TWO);
    end

endmodule

// File: rtl/signed_saturator.sv
// -----------------------------------------------------------------------------
// signed_saturator
// Narrows a signed in_width stream to out_width, by saturation or wrapping,
// flags overflowed beats, keeps a sticky overflow flag and (optionally) a
// saturating overflow counter. Output is decoupled by a 2-entry skid buffer.
// Optional feature macro: SIGNED_SATURATOR_STATS_EN adds ovf_count.
// Parameters: in_width, out_width (2..in_width), method ("SATURATE"/"WRAP"),
//             cnt_width.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   bus (slave)   : s_valid/s_ready/s_data in, m_valid/m_ready/m_data/m_ovf out
//   clr_sticky    : one-cycle clear of ovf_sticky (and ovf_count)
//   ovf_sticky    : an overflow has been accepted since reset/clear
//   ovf_count     : saturating overflow count (SIGNED_SATURATOR_STATS_EN only)
// -----------------------------------------------------------------------------
module signed_saturator
    import signed_saturator_pkg::*;
#(
    parameter int          in_width  = 8,
    parameter int          out_width = 6,
    parameter logic [63:0] method    = "SATURATE",
    parameter int          cnt_width = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    signed_saturator_if.slave    bus,
    input  logic                 clr_sticky,
    output logic                 ovf_sticky
`ifdef SIGNED_SATURATOR_STATS_EN
    ,
    output logic [cnt_width-1:0] ovf_count
`endif
);

    localparam overflow_method mode = method_from_string(method);

    generate
        if (out_width < 2 || out_width > in_width) begin : g_bad_width
            $error("signed_saturator: out_width must satisfy 2 <= out_width <= in_width");
        end
        if (!method_valid(method)) begin : g_bad_method
            $error("signed_saturator: method must be \"SATURATE\" or \"WRAP\"");
        end
        if (cnt_width < 1) begin : g_bad_cnt
            $error("signed_saturator: cnt_width must be at least 1");
        end
    endgenerate

    logic                 ovf;
    logic                 sign;
    logic [out_width-1:0] sat_value;
    logic [out_width-1:0] result;
    logic [out_width:0]   m_payload;
    logic                 ovf_beat;
    logic                 ovf_sticky_q, ovf_sticky_d;

    assign sign = bus.s_data[in_width-1];

    // A value fits when every bit from the sign down to the new sign bit
    // agrees; this is the full-width range test without a comparator.
    generate
        if (out_width == in_width) begin : g_pass
            assign ovf = 1'b0;
        end else begin : g_narrow
            logic [in_width-out_width:0] upper;
            assign upper = bus.s_data[in_width-1:out_width-1];
            assign ovf   = !((&upper) || !(|upper));
        end
    endgenerate

    // MAX when positive overflow, MIN when negative.
    assign sat_value = {sign, {(out_width-1){~sign}}};

    always_comb begin
        result = bus.s_data[out_width-1:0];
        if (mode == saturate && ovf) begin
            result = sat_value;
        end
    end

    skid_buffer #(
        .width (out_width + 1)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .s_valid_i (bus.s_valid),
        .s_ready_o (bus.s_ready),
        .s_data_i  ({ovf, result}),
        .m_valid_o (bus.m_valid),
        .m_ready_i (bus.m_ready),
        .m_data_o  (m_payload)
    );

    assign bus.m_ovf  = m_payload[out_width];
    assign bus.m_data = m_payload[out_width-1:0];

    assign ovf_beat = bus.s_valid && bus.s_ready && ovf;

    // Set beats a coincident clear.
    always_comb begin
        ovf_sticky_d = ovf_sticky_q;
        if (clr_sticky) ovf_sticky_d = 1'b0;
        if (ovf_beat)   ovf_sticky_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) ovf_sticky_q <= 1'b0;
        else     ovf_sticky_q <= ovf_sticky_d;
    end

    assign ovf_sticky = ovf_sticky_q;

`ifdef SIGNED_SATURATOR_STATS_EN
    logic [cnt_width-1:0] ovf_count_q, ovf_count_d;

    // Clear with a coincident overflow restarts the count at 1.
    always_comb begin
        ovf_count_d = ovf_count_q;
        if (clr_sticky) begin
            ovf_count_d = cnt_width'(ovf_beat);
        end else if (ovf_beat && !(&ovf_count_q)) begin
            ovf_count_d = ovf_count_q + cnt_width'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) ovf_count_q <= '0;
        else     ovf_count_q <= ovf_count_d;
    end

    assign ovf_count = ovf_count_q;
`endif

endmodule

// File: tb/tb_signed_saturator.sv
module tb_signed_saturator;
    import signed_saturator_pkg::*;

    localparam int IW = 8;
    localparam int OW = 6;
    localparam int CW = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic                 drv_valid;
    logic                 drv_ready;
    logic                 drv_clr;
    logic signed [IW-1:0] drv_data;
    logic                 sticky_sat, sticky_wrap;
`ifdef SIGNED_SATURATOR_STATS_EN
    logic [CW-1:0]        cnt_sat, cnt_wrap;
`endif

    signed_saturator_if #(.in_width(IW), .out_width(OW)) if_sat ();
    signed_saturator_if #(.in_width(IW), .out_width(OW)) if_wrap ();

    assign if_sat.s_valid  = drv_valid;
    assign if_sat.s_data   = drv_data;
    assign if_sat.m_ready  = drv_ready;
    assign if_wrap.s_valid = drv_valid;
    assign if_wrap.s_data  = drv_data;
    assign if_wrap.m_ready = drv_ready;

    signed_saturator #(.in_width(IW), .out_width(OW), .method("SATURATE"), .cnt_width(CW)) u_sat (
        .clk        (clk),
        .rst        (rst),
        .bus        (if_sat),
        .clr_sticky (drv_clr),
        .ovf_sticky (sticky_sat)
`ifdef SIGNED_SATURATOR_STATS_EN
        ,
        .ovf_count  (cnt_sat)
`endif
    );

    signed_saturator #(.in_width(IW), .out_width(OW), .method("WRAP"), .cnt_width(CW)) u_wrap (
        .clk        (clk),
        .rst        (rst),
        .bus        (if_wrap),
        .clr_sticky (drv_clr),
        .ovf_sticky (sticky_wrap)
`ifdef SIGNED_SATURATOR_STATS_EN
        ,
        .ovf_count  (cnt_wrap)
`endif
    );

    typedef struct {
        int data;
        bit ovf;
    } exp_t;

    exp_t q_sat[$];
    exp_t q_wrap[$];
    int   checks = 0;
    int   errors = 0;
    int   pops_sat = 0;
    bit   rnd_done = 1'b0;

    // Reference: range arithmetic on plain integers.
    function automatic void model(input int x, output exp_t s, output exp_t w);
        int lo   = -(2 ** (OW - 1));
        int hi   = (2 ** (OW - 1)) - 1;
        int span = 2 ** OW;
        int m;
        bit o    = (x > hi) || (x < lo);
        s.ovf  = o;
        w.ovf  = o;
        s.data = (x > hi) ? hi : ((x < lo) ? lo : x);
        m = (x - lo) % span;
        if (m < 0) m = m + span;
        w.data = m + lo;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Holds a beat until accepted; expectation is queued when the accept is seen.
    task automatic send(input int x);
        int             n;
        exp_t           s, w;
        narrow_result_t r;
        logic [31:0]    xv;
        xv        = x;
        drv_valid = 1'b1;
        drv_data  = xv[IW-1:0];
        n = 0;
        forever begin
            @(negedge clk);
            if (if_sat.s_ready) begin
                model(x, s, w);
                q_sat.push_back(s);
                q_wrap.push_back(w);
                r = narrow_explicit(longint'(x), OW, saturate);
                check("pkg_narrow_sat", int'(r.result), s.data);
                r = narrow_explicit(longint'(x), OW, wrap);
                check("pkg_narrow_wrap", int'(r.result), w.data);
                @(posedge clk);
                #1;
                drv_valid = 1'b0;
                return;
            end
            n++;
            if (n > 200) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: beat %0d not accepted within 200 cycles", x);
                drv_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: pops on every output handshake and checks order/content/hold.
    initial begin : monitor
        bit hold_prev = 1'b0;
        int prev_data = 0;
        int prev_ovf  = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                hold_prev = 1'b0;
            end else begin
                if (hold_prev) begin
                    check("hold_valid", int'(if_sat.m_valid), 1);
                    check("hold_data", int'(if_sat.m_data), prev_data);
                    check("hold_ovf", int'(if_sat.m_ovf), prev_ovf);
                end
                hold_prev = if_sat.m_valid && !if_sat.m_ready;
                prev_data = int'(if_sat.m_data);
                prev_ovf  = int'(if_sat.m_ovf);
                if (if_sat.m_valid && if_sat.m_ready) begin
                    if (q_sat.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL sat_unexpected: got %0d expected no beat", int'(if_sat.m_data));
                    end else begin
                        e = q_sat.pop_front();
                        check("sat_data", int'(if_sat.m_data), e.data);
                        check("sat_ovf", int'(if_sat.m_ovf), int'(e.ovf));
                        pops_sat++;
                    end
                end
                if (if_wrap.m_valid && if_wrap.m_ready) begin
                    if (q_wrap.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL wrap_unexpected: got %0d expected no beat", int'(if_wrap.m_data));
                    end else begin
                        e = q_wrap.pop_front();
                        check("wrap_data", int'(if_wrap.m_data), e.data);
                        check("wrap_ovf", int'(if_wrap.m_ovf), int'(e.ovf));
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int base;
        int n;
        int dir_vals[8] = '{100, -100, 31, -32, 0, 40, -40, 5};
        int ovf_vals[5] = '{100, -100, 50, -50, 127};

        drv_valid = 1'b0;
        drv_data  = '0;
        drv_ready = 1'b1;
        drv_clr   = 1'b0;
        rst       = 1'b1;
        cycles(3);

        check("rst_s_ready_sat", int'(if_sat.s_ready), 0);
        check("rst_s_ready_wrap", int'(if_wrap.s_ready), 0);
        check("rst_m_valid", int'(if_sat.m_valid), 0);
        check("rst_m_data", int'(if_sat.m_data), 0);
        check("rst_m_ovf", int'(if_sat.m_ovf), 0);
        check("rst_sticky", int'(sticky_sat), 0);
`ifdef SIGNED_SATURATOR_STATS_EN
        check("rst_count", int'(cnt_sat), 0);
`endif
        rst = 1'b0;
        cycles(1);
        check("s_ready_after_rst", int'(if_sat.s_ready), 1);

        // Directed values from both narrowing modes.
        foreach (dir_vals[i]) begin
            send(dir_vals[i]);
            if (i == 0) check("sticky_first_ovf", int'(sticky_sat), 1);
        end
        cycles(3);

        drv_clr = 1'b1;
        cycles(1);
        drv_clr = 1'b0;
        check("sticky_cleared", int'(sticky_sat), 0);
`ifdef SIGNED_SATURATOR_STATS_EN
        check("count_cleared", int'(cnt_sat), 0);
`endif
        foreach (ovf_vals[i]) send(ovf_vals[i]);
        check("sticky_after_ovf", int'(sticky_wrap), 1);
`ifdef SIGNED_SATURATOR_STATS_EN
        check("count_saturates", int'(cnt_sat), 3);
`endif
        drv_clr = 1'b1;
        send(-128);
        drv_clr = 1'b0;
        check("sticky_set_wins", int'(sticky_sat), 1);
`ifdef SIGNED_SATURATOR_STATS_EN
        check("count_clr_and_inc", int'(cnt_sat), 1);
`endif
        cycles(3);

        // Backpressure: two beats fill the buffer, third must stall.
        drv_ready = 1'b0;
        send(1);
        send(2);
        drv_valid = 1'b1;
        drv_data  = 8'sd3;
        @(negedge clk);
        check("bp_s_ready_low", int'(if_sat.s_ready), 0);
        @(posedge clk);
        #1;
        drv_ready = 1'b1;
        fork
            begin
                send(3);
                send(4);
            end
            begin
                repeat (4) begin
                    @(negedge clk);
                    check("bp_no_gap", int'(if_sat.m_valid), 1);
                end
            end
        join
        cycles(3);

        // Reset while both registers are full.
        drv_ready = 1'b0;
        send(10);
        send(20);
        rst = 1'b1;
        cycles(1);
        check("rst_mid_m_valid", int'(if_sat.m_valid), 0);
        q_sat.delete();
        q_wrap.delete();
        rst = 1'b0;
        drv_ready = 1'b1;
        cycles(1);
        check("s_ready_after_mid_rst", int'(if_sat.s_ready), 1);
        base = pops_sat;
        send(7);
        cycles(4);
        check("rst_single_beat", pops_sat - base, 1);

        // Random stream with 70% downstream ready.
        fork
            begin
                for (int i = 0; i < 10000; i++) begin
                    if ($urandom_range(0, 9) < 2) cycles(1);
                    if ($urandom_range(0, 1) == 1) send(int'($urandom_range(0, 255)) - 128);
                    else                          send(int'($urandom_range(0, 80)) - 40);
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    drv_ready = ($urandom_range(0, 99) < 70);
                    @(posedge clk);
                    #1;
                end
            end
        join
        drv_ready = 1'b1;
        n = 0;
        while ((q_sat.size() != 0 || q_wrap.size() != 0) && n < 100) begin
            cycles(1);
            n++;
        end
        check("drain_empty", q_sat.size() + q_wrap.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
